cache_fill_ctrl: RTL

Line fill/writeback sequencer between the direct-mapped cache array and the four-banked main memory. On a miss it optionally writes the dirty victim line back, then reads the four-word refill line, honours bank stalls, and writes each returned word into the cache. It is the reader side of the per-bit register storage used for the tag, valid and dirty bits: it consumes those stored values and drives the fill writes into the data array.

---
 rtl/cache_fill_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl
// Line fill / writeback sequencer between a direct-mapped cache array and a
// four-banked main memory. On a miss it optionally writes the dirty victim
// line back (four words), then issues the four refill reads. Each returned
// word is written into the cache data array. The last word also sets valid,
// writes the fill tag and clears dirty.
//
// Address split: tag [15:11], index [10:3], offset [2:0] (word-aligned, bit 0 = 0).
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start             fill request, sampled only in IDLE together with
//                     dirty / victim_tag / fill_tag / index
//   cache_data_in     victim word at cache_offset (combinational array read)
//   mem_data_in       memory read data, two cycles after an accepted read
//   mem_stall         bank busy: this cycle's request is not accepted
//   mem_addr/rd/wr    memory request; mem_data_out carries writeback data
//   cache_offset      word offset into the line, {word,1'b0}
//   cache_wr          write cache_data_out into the array at index/cache_offset
//   cache_valid_set   set valid, write fill tag, clear dirty (with last word)
//   busy              high in every state except IDLE
//   done              one-cycle completion pulse
//
// Memory handshake: mem_rd / mem_wr act as valid and !mem_stall as ready.
// A request is accepted in a cycle where it is high and mem_stall is low.
// While stalled, the request and all its fields hold stable until accepted.
module cache_fill_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dirty,
  input  logic [4:0]  victim_tag,
  input  logic [4:0]  fill_tag,
  input  logic [7:0]  index,
  input  logic [15:0] cache_data_in,
  input  logic [15:0] mem_data_in,
  input  logic        mem_stall,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_data_out,
  output logic [2:0]  cache_offset,
  output logic        cache_wr,
  output logic [15:0] cache_data_out,
  output logic        cache_valid_set,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } stateT;

  stateT      state;
  stateT      nextState;

  logic [1:0] ic;          // issue counter, word 0..3 of the current burst
  logic [4:0] victimTagQ;
  logic [4:0] fillTagQ;
  logic [7:0] indexQ;

  // Two-stage return pipe: stage 0 captures an accepted read, stage 1 lines
  // up with the cycle its data appears on mem_data_in.
  logic       pipeVld0;
  logic       pipeVld1;
  logic [1:0] pipeIdx0;
  logic [1:0] pipeIdx1;

  logic       rdAccept;
  logic       retValid;
  logic       retLast;

  assign rdAccept = (state == RD) && !mem_stall;
  assign retValid = pipeVld1 && ((state == RD) || (state == DRAIN));
  assign retLast  = retValid && (pipeIdx1 == 2'd3);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = dirty ? WB : RD;
        end
      end
      WB: begin
        if (!mem_stall && (ic == 2'd3)) begin
          nextState = RD;
        end
      end
      RD: begin
        if (retLast) begin
          nextState = DONE;
        end else if (rdAccept && (ic == 2'd3)) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (retLast) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Datapath registers: request latches, issue counter, return pipe.
  // The pipe shifts every cycle; a stalled read enters as a bubble, so an
  // accepted read is never dropped or duplicated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic         <= 2'd0;
      victimTagQ <= 5'd0;
      fillTagQ   <= 5'd0;
      indexQ     <= 8'd0;
      pipeVld0   <= 1'b0;
      pipeVld1   <= 1'b0;
      pipeIdx0   <= 2'd0;
      pipeIdx1   <= 2'd0;
    end else begin
      pipeVld0 <= rdAccept;
      pipeIdx0 <= ic;
      pipeVld1 <= pipeVld0;
      pipeIdx1 <= pipeIdx0;
      case (state)
        IDLE: begin
          if (start) begin
            victimTagQ <= victim_tag;
            fillTagQ   <= fill_tag;
            indexQ     <= index;
            ic         <= 2'd0;
          end
        end
        // ic wraps 3 -> 0 on the last accept, so RD starts at word 0
        WB, RD: begin
          if (!mem_stall) begin
            ic <= ic + 2'd1;
          end
        end
        default: begin
          ic <= ic;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    mem_addr        = 16'd0;
    mem_rd          = 1'b0;
    mem_wr          = 1'b0;
    mem_data_out    = 16'd0;
    cache_offset    = 3'd0;
    cache_wr        = 1'b0;
    cache_data_out  = 16'd0;
    cache_valid_set = 1'b0;
    busy            = (state != IDLE);
    done            = (state == DONE);
    case (state)
      WB: begin
        mem_wr       = 1'b1;
        mem_addr     = {victimTagQ, indexQ, ic, 1'b0};
        cache_offset = {ic, 1'b0};
        mem_data_out = cache_data_in;
      end
      RD: begin
        mem_rd   = 1'b1;
        mem_addr = {fillTagQ, indexQ, ic, 1'b0};
      end
      default: begin
        mem_rd = 1'b0;
      end
    endcase
    // Returns land in RD and DRAIN; cache_offset is free there because
    // it only addresses the victim read during WB.
    if (retValid) begin
      cache_wr        = 1'b1;
      cache_offset    = {pipeIdx1, 1'b0};
      cache_data_out  = mem_data_in;
      cache_valid_set = (pipeIdx1 == 2'd3);
    end
  end

endmodule
